// File: rtl/sysid_check_sequencer.sv
// -----------------------------------------------------------------------------
// sysid_check_sequencer
//
// Boot-time checker for the system-ID slave. After a start pulse it reads
// word 0 (ID) and then word 1 (timestamp) over Avalon-MM, keeping at most one
// read outstanding. It compares both words against build-time constants and
// reports the result on sticky status flags. A read that gets no data within
// TIMEOUT_CYCLES restarts the whole sequence after a short gap, up to
// MAX_RETRIES times. After that the checker gives up and raises timeout_err.
//
// Ports
//   clock, reset         system clock, asynchronous active-high reset
//   start                begin a check sequence (only sampled while idle)
//   busy                 sequence in progress
//   done                 one-cycle pulse when the sequence ends
//   pass                 both words matched
//   id_mismatch          word 0 differed from EXPECTED_ID
//   ts_mismatch          word 1 differed from EXPECTED_TIMESTAMP
//   timeout_err          retries exhausted without a complete sequence
//   id_value, ts_value   last captured word 0 / word 1
//   avm_*                Avalon-MM read master interface
// -----------------------------------------------------------------------------
module sysid_check_sequencer #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1487792956,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ID, S_WT_ID, S_RD_TS, S_WT_TS, S_CHECK, S_GAP, S_DONE
    } state_t;

    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  MAX_RETRY_L = 8'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]  retry_cnt_q, retry_cnt_d;
    logic [1:0]  gap_cnt_q, gap_cnt_d;
    logic        pass_q, pass_d;
    logic        id_mm_q, id_mm_d;
    logic        ts_mm_q, ts_mm_d;
    logic        tmo_err_q, tmo_err_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rd_q, rd_d;
    logic        addr_q, addr_d;
    logic        rd_phase;
    logic        id_phase;
    logic        rsp_hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tmo_cnt_q   <= '0;
            retry_cnt_q <= '0;
            gap_cnt_q   <= '0;
            pass_q      <= 1'b0;
            id_mm_q     <= 1'b0;
            ts_mm_q     <= 1'b0;
            tmo_err_q   <= 1'b0;
            id_value_q  <= '0;
            ts_value_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            pass_q      <= pass_d;
            id_mm_q     <= id_mm_d;
            ts_mm_q     <= ts_mm_d;
            tmo_err_q   <= tmo_err_d;
            id_value_q  <= id_value_d;
            ts_value_q  <= ts_value_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        retry_cnt_d = retry_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        pass_d      = pass_q;
        id_mm_d     = id_mm_q;
        ts_mm_d     = ts_mm_q;
        tmo_err_d   = tmo_err_q;
        id_value_d  = id_value_q;
        ts_value_d  = ts_value_q;
        rd_phase    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
        id_phase    = (state_q == S_RD_ID) || (state_q == S_WT_ID);
        rsp_hit     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RD_ID;
                    pass_d      = 1'b0;
                    id_mm_d     = 1'b0;
                    ts_mm_d     = 1'b0;
                    tmo_err_d   = 1'b0;
                    retry_cnt_d = '0;
                    tmo_cnt_d   = '0;
                end
            end

            S_RD_ID, S_WT_ID, S_RD_TS, S_WT_TS: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                // Data in the accept cycle itself counts only once the
                // slave has stopped stalling.
                rsp_hit = rd_phase ? (!avm_waitrequest && avm_readdatavalid)
                                   : avm_readdatavalid;
                // A capture wins over a timeout landing in the same cycle.
                if (rsp_hit) begin
                    if (id_phase) begin
                        id_value_d = avm_readdata;
                        state_d    = S_RD_TS;
                        tmo_cnt_d  = '0;
                    end else begin
                        ts_value_d = avm_readdata;
                        state_d    = S_CHECK;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Leaving the read states drops avm_read even if the
                    // slave is still stalling; this is the recovery path.
                    if (retry_cnt_q < MAX_RETRY_L) begin
                        retry_cnt_d = retry_cnt_q + 8'd1;
                        gap_cnt_d   = '0;
                        state_d     = S_GAP;
                    end else begin
                        tmo_err_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end else if (rd_phase && !avm_waitrequest) begin
                    state_d = id_phase ? S_WT_ID : S_WT_TS;
                end
            end

            // Quiet period that swallows late responses from an abandoned
            // read before the sequence restarts from word 0.
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + 2'd1;
                if (gap_cnt_q == 2'd3) begin
                    state_d   = S_RD_ID;
                    tmo_cnt_d = '0;
                end
            end

            S_CHECK: begin
                id_mm_d = (id_value_q != EXPECTED_ID);
                ts_mm_d = (ts_value_q != EXPECTED_TIMESTAMP);
                pass_d  = (id_value_q == EXPECTED_ID) &&
                          (ts_value_q == EXPECTED_TIMESTAMP);
                state_d = S_DONE;
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs are derived from the next state so they line up
    // with the state they describe.
    always_comb begin
        rd_d   = (state_d == S_RD_ID) || (state_d == S_RD_TS);
        addr_d = (state_d == S_RD_TS);
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_mismatch = id_mm_q;
    assign ts_mismatch = ts_mm_q;
    assign timeout_err = tmo_err_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;
    assign avm_address = addr_q;
    assign avm_read    = rd_q;

endmodule
